// File: rtl/econet_tx_sequencer_if.sv
// Frame-buffer read port and transmitter byte handshake of the Econet TX sequencer.
interface econet_tx_sequencer_if #(
  parameter int LEN_W = 11
);
  logic [LEN_W-1:0] buf_addr;
  logic [7:0]       buf_data;
  logic [7:0]       tx_data;
  logic             tx_data_available;
  logic             tx_data_consumed;
  logic             tx_eop;
  logic             tx_flag_fill;

  modport master (
    output buf_addr, tx_data, tx_data_available, tx_eop, tx_flag_fill,
    input  buf_data, tx_data_consumed
  );

  modport slave (
    input  buf_addr, tx_data, tx_data_available, tx_eop, tx_flag_fill,
    output buf_data, tx_data_consumed
  );
endinterface

// File: rtl/econet_tx_sequencer.sv
// Econet frame-level transmit controller: line-quiet wait, flag preamble, byte
// streaming from a synchronous frame buffer, and bounded retry with exponential backoff.
module econet_tx_sequencer #(
  parameter int LEN_W           = 11,
  parameter int IDLE_CYCLES     = 128,
  parameter int PREAMBLE_CYCLES = 256,
  parameter int TAIL_CYCLES     = 64,
  parameter int MAX_RETRIES     = 3,
  parameter int BACKOFF_BASE    = 512
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      frame_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  line_idle,
  input  logic                  line_abort,
  econet_tx_sequencer_if.master bus
);
  localparam int BO_MAX  = (MAX_RETRIES > 0) ? (BACKOFF_BASE << (MAX_RETRIES - 1)) : BACKOFF_BASE;
  localparam int M1      = (IDLE_CYCLES > PREAMBLE_CYCLES) ? IDLE_CYCLES : PREAMBLE_CYCLES;
  localparam int M2      = (TAIL_CYCLES > BO_MAX) ? TAIL_CYCLES : BO_MAX;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BO_BASE   = CNT_W'(BACKOFF_BASE);
  localparam logic [RTY_W-1:0] MAX_RTY   = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE, WAIT_LINE, PREAMBLE, FETCH, LOAD, SEND, TAIL, BACKOFF
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [LEN_W-1:0] addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             avail_q, avail_d;
  logic             eop_q, eop_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] bo_last;
  logic             abortable;

  // retry_q already holds the 1-based retry number while in BACKOFF
  assign bo_last = (BO_BASE << (retry_q - RTY_W'(1))) - CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    avail_d   = avail_q;
    eop_d     = eop_q;
    flag_d    = flag_q;
    abortable = state_q inside {PREAMBLE, FETCH, LOAD, SEND, TAIL};

    if (line_abort && abortable) begin
      // abort outranks a same-cycle consume or the final tail cycle
      flag_d  = 1'b0;
      avail_d = 1'b0;
      eop_d   = 1'b0;
      idx_d   = '0;
      addr_d  = '0;
      cnt_d   = '0;
      if (retry_q < MAX_RTY) begin
        retry_d = retry_q + RTY_W'(1);
        state_d = BACKOFF;
      end else begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_d   = frame_len;
            retry_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
            if (frame_len == '0) begin
              error_d = 1'b1;
            end else begin
              busy_d  = 1'b1;
              state_d = WAIT_LINE;
            end
          end
        end
        WAIT_LINE: begin
          if (!line_idle) begin
            cnt_d = '0;
          end else if (cnt_q == IDLE_LAST) begin
            cnt_d   = '0;
            flag_d  = 1'b1;
            state_d = PREAMBLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PREAMBLE: begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            flag_d  = 1'b0;
            addr_d  = idx_q;
            state_d = FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          data_d  = bus.buf_data;
          avail_d = 1'b1;
          eop_d   = (idx_q == len_q - LEN_W'(1));
          state_d = SEND;
        end
        SEND: begin
          if (bus.tx_data_consumed) begin
            avail_d = 1'b0;
            eop_d   = 1'b0;
            if (eop_q) begin
              cnt_d   = '0;
              state_d = TAIL;
            end else begin
              idx_d   = idx_q + LEN_W'(1);
              addr_d  = idx_q + LEN_W'(1);
              state_d = FETCH;
            end
          end
        end
        TAIL: begin
          if (cnt_q == TAIL_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BACKOFF: begin
          if (cnt_q == bo_last) begin
            cnt_d   = '0;
            state_d = WAIT_LINE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      avail_q <= 1'b0;
      eop_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      avail_q <= avail_d;
      eop_q   <= eop_d;
      flag_q  <= flag_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;
  assign bus.buf_addr          = addr_q;
  assign bus.tx_data           = data_q;
  assign bus.tx_data_available = avail_q;
  assign bus.tx_eop            = eop_q;
  assign bus.tx_flag_fill      = flag_q;
endmodule

// File: tb/tb_econet_tx_sequencer.sv
// Self-checking bench for econet_tx_sequencer: a transmitter/receiver model with
// a byte scoreboard, timing checks on preamble, tail, backoff and retry exhaustion.
module tb_econet_tx_sequencer;
  localparam int LEN_W           = 11;
  localparam int IDLE_CYCLES     = 128;
  localparam int PREAMBLE_CYCLES = 256;
  localparam int TAIL_CYCLES     = 64;
  localparam int MAX_RETRIES     = 3;
  localparam int BACKOFF_BASE    = 512;
  localparam int CONSUME_DLY     = 20;

  typedef struct packed {
    logic       eop;
    logic [7:0] data;
  } exp_t;

  logic             mclk = 1'b0;
  logic             reset, start, busy, done, error, line_idle, line_abort;
  logic [LEN_W-1:0] frame_len;
  logic [7:0]       mem [0:15];
  exp_t             sb_q [$];

  int checks = 0, errors = 0, cyc = 0;
  int wait_cnt, flag_hi, flag_rise_cyc, flag_len, busy_rise_cyc, busy_fall_cyc;
  int done_cnt, error_cnt, done_cyc, error_cyc, consume_cnt, consume_cyc;
  int abort_cyc, aborts_fired, frame_aborts, abort_mode, abort_byte, abort_limit;
  int byte_in_attempt, cur_len;
  int d0, e0, c0, a0;
  logic flag_prev, busy_prev, avail_prev, gap_armed, post_abort, abort_pending_rise;

  econet_tx_sequencer_if #(.LEN_W(LEN_W)) bus ();

  econet_tx_sequencer #(
    .LEN_W(LEN_W), .IDLE_CYCLES(IDLE_CYCLES), .PREAMBLE_CYCLES(PREAMBLE_CYCLES),
    .TAIL_CYCLES(TAIL_CYCLES), .MAX_RETRIES(MAX_RETRIES), .BACKOFF_BASE(BACKOFF_BASE)
  ) dut (
    .mclk(mclk), .reset(reset), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .error(error),
    .line_idle(line_idle), .line_abort(line_abort), .bus(bus)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) bus.buf_data <= mem[bus.buf_addr[3:0]];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic load_expected();
    exp_t e;
    sb_q.delete();
    for (int i = 0; i < cur_len; i++) begin
      e.eop  = (i == cur_len - 1);
      e.data = mem[i];
      sb_q.push_back(e);
    end
  endtask

  task automatic fire_abort();
    line_abort         = 1'b1;
    aborts_fired++;
    frame_aborts++;
    abort_cyc          = cyc;
    byte_in_attempt    = 0;
    gap_armed          = 1'b0;
    post_abort         = 1'b1;
    abort_pending_rise = 1'b1;
    load_expected();
  endtask

  // One mclk cycle: observe at the falling edge, then drive the model's inputs.
  task automatic tick();
    exp_t e;
    @(negedge mclk);
    cyc++;
    if (line_abort) line_abort = 1'b0;
    if (post_abort) begin
      check_eq("abort_clears_outputs", {bus.tx_flag_fill, bus.tx_data_available, bus.tx_eop}, 0);
      post_abort = 1'b0;
    end
    if (bus.tx_flag_fill && !flag_prev) begin
      flag_rise_cyc = cyc;
      if (abort_pending_rise) begin
        check_eq("backoff_gap", cyc - abort_cyc,
                 1 + (BACKOFF_BASE << (frame_aborts - 1)) + IDLE_CYCLES);
        abort_pending_rise = 1'b0;
      end
    end
    if (!bus.tx_flag_fill && flag_prev) flag_len = cyc - flag_rise_cyc;
    if (busy && !busy_prev) busy_rise_cyc = cyc;
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (error) begin error_cnt++; error_cyc = cyc; end
    if (done || error) check_eq("done_error_exclusive", int'(done & error), 0);
    if (bus.tx_data_available && !avail_prev && gap_armed) begin
      check_eq("byte_gap", cyc - consume_cyc, 3);
      gap_armed = 1'b0;
    end
    flag_hi = bus.tx_flag_fill ? flag_hi + 1 : 0;
    if (abort_mode == 3 && flag_hi == 10 && aborts_fired < abort_limit) fire_abort();
    if (bus.tx_data_consumed) begin
      bus.tx_data_consumed = 1'b0;
    end else if (bus.tx_data_available) begin
      wait_cnt++;
      if (abort_mode == 1 && wait_cnt == 5 && byte_in_attempt == abort_byte &&
          aborts_fired < abort_limit) begin
        fire_abort();
      end else if (wait_cnt == CONSUME_DLY) begin
        bus.tx_data_consumed = 1'b1;
        wait_cnt    = 0;
        consume_cyc = cyc;
        consume_cnt++;
        check_eq("sb_has_entry", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("sb_data", bus.tx_data, e.data);
          check_eq("sb_eop", bus.tx_eop, e.eop);
        end
        byte_in_attempt++;
        gap_armed = !bus.tx_eop;
        if (abort_mode == 2 && byte_in_attempt - 1 == abort_byte && aborts_fired < abort_limit)
          fire_abort();
      end
    end else begin
      wait_cnt = 0;
    end
    flag_prev  = bus.tx_flag_fill;
    busy_prev  = busy;
    avail_prev = bus.tx_data_available;
  endtask

  task automatic snap();
    d0 = done_cnt; e0 = error_cnt; c0 = consume_cnt; a0 = aborts_fired;
  endtask

  task automatic send_start(input int len);
    cur_len = len;
    frame_len = LEN_W'(len);
    frame_aborts = 0;
    abort_pending_rise = 1'b0;
    load_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (done_cnt == d0 && error_cnt == e0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("frame_end_seen", int'(done_cnt != d0 || error_cnt != e0), 1);
  endtask

  task automatic check_frame(input string tag, input int consumes, input int dones,
                             input int errs);
    check_eq({tag, "_consumes"}, consume_cnt - c0, consumes);
    check_eq({tag, "_dones"}, done_cnt - d0, dones);
    check_eq({tag, "_errors"}, error_cnt - e0, errs);
    check_eq({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_buf_addr"}, bus.buf_addr, 0);
    check_eq({tag, "_tx_data"}, bus.tx_data, 0);
    check_eq({tag, "_avail"}, bus.tx_data_available, 0);
    check_eq({tag, "_eop"}, bus.tx_eop, 0);
    check_eq({tag, "_flag"}, bus.tx_flag_fill, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_len = '0; line_idle = 1'b1; line_abort = 1'b0;
    bus.tx_data_consumed = 1'b0;
    wait_cnt = 0; flag_hi = 0; flag_rise_cyc = 0; flag_len = 0; busy_rise_cyc = 0;
    busy_fall_cyc = 0; done_cnt = 0; error_cnt = 0; done_cyc = 0; error_cyc = 0;
    consume_cnt = 0; consume_cyc = 0; abort_cyc = 0; aborts_fired = 0; frame_aborts = 0;
    abort_mode = 0; abort_byte = 0; abort_limit = 0; byte_in_attempt = 0; cur_len = 0;
    flag_prev = 1'b0; busy_prev = 1'b0; avail_prev = 1'b0; gap_armed = 1'b0;
    post_abort = 1'b0; abort_pending_rise = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // single byte
    mem[0] = 8'h53;
    snap(); byte_in_attempt = 0;
    send_start(1);
    check_eq("s1_busy_rise", busy, 1);
    wait_end(2000);
    check_eq("s1_flag_start", flag_rise_cyc - busy_rise_cyc, IDLE_CYCLES);
    check_eq("s1_flag_len", flag_len, PREAMBLE_CYCLES);
    check_eq("s1_done_delay", done_cyc - consume_cyc, TAIL_CYCLES + 1);
    check_eq("s1_busy_fall", busy_fall_cyc, done_cyc);
    check_frame("s1", 1, 1, 0);
    tick();
    check_eq("s1_done_pulse", done, 0);

    // multi-byte, with a stray start while busy
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
    snap(); byte_in_attempt = 0;
    send_start(4);
    repeat (50) tick();
    frame_len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("s2_busy_after_stray_start", busy, 1);
    wait_end(3000);
    check_frame("s2", 4, 1, 0);

    // line goes busy when the quiet counter is at 100
    mem[0] = 8'h77;
    snap(); byte_in_attempt = 0;
    send_start(1);
    repeat (100) tick();
    line_idle = 1'b0;
    tick();
    line_idle = 1'b1;
    wait_end(3000);
    check_eq("s3_flag_start", flag_rise_cyc - busy_rise_cyc, 101 + IDLE_CYCLES);
    check_frame("s3", 1, 1, 0);

    // collision during byte 2 of 3
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    snap(); byte_in_attempt = 0;
    abort_mode = 1; abort_byte = 1; abort_limit = aborts_fired + 1;
    send_start(3);
    wait_end(5000);
    abort_mode = 0;
    check_eq("s4_aborts", aborts_fired - a0, 1);
    check_frame("s4", 4, 1, 0);

    // abort and consume in the same cycle
    mem[0] = 8'h5A; mem[1] = 8'hA5;
    snap(); byte_in_attempt = 0;
    abort_mode = 2; abort_byte = 0; abort_limit = aborts_fired + 1;
    send_start(2);
    wait_end(5000);
    abort_mode = 0;
    check_eq("s5_aborts", aborts_fired - a0, 1);
    check_frame("s5", 3, 1, 0);

    // retries exhausted by preamble aborts
    snap(); byte_in_attempt = 0;
    abort_mode = 3; abort_limit = aborts_fired + 4;
    send_start(2);
    wait_end(8000);
    abort_mode = 0;
    check_eq("s6_aborts", aborts_fired - a0, 4);
    check_eq("s6_error_delay", error_cyc - abort_cyc, 1);
    check_eq("s6_busy_fall", busy_fall_cyc, error_cyc);
    check_eq("s6_consumes", consume_cnt - c0, 0);
    check_eq("s6_dones", done_cnt - d0, 0);
    check_eq("s6_errors", error_cnt - e0, 1);
    tick();
    check_eq("s6_error_pulse", error, 0);

    // zero-length start
    snap();
    send_start(0);
    check_eq("s7_error", error, 1);
    check_eq("s7_busy", busy, 0);
    tick();
    check_eq("s7_error_pulse", error, 0);
    check_eq("s7_busy_after", busy, 0);

    // reset while a byte is waiting in SEND, then a clean frame
    mem[0] = 8'h3C; mem[1] = 8'hC3;
    snap(); byte_in_attempt = 0;
    send_start(2);
    for (int n = 0; n < 1000 && !bus.tx_data_available; n++) tick();
    check_eq("s8_reached_send", bus.tx_data_available, 1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_outputs_zero("s8_reset");
    check_eq("s8_no_done", done_cnt - d0, 0);
    check_eq("s8_no_error", error_cnt - e0, 0);
    reset = 1'b0;
    tick();
    snap(); byte_in_attempt = 0;
    send_start(2);
    wait_end(3000);
    check_frame("s8_restart", 2, 1, 0);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
